// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } lsu_fault_t;

    // Access width as encoded in funct3[1:0]; funct3[2] selects zero-extension.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Loads accept 000,001,010,100,101; stores only 000,001,010.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == SIZE_HALF) && off[0]) ||
               ((f3[1:0] == SIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load-value extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store side: byte enables and lane-replicated write data
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        unique case (funct3_i[1:0])
            SIZE_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

    // Load side: select the addressed lane and sign/zero extend
    always_comb begin
        byte_v  = rdata_i[{off_i, 3'b000} +: 8];
        half_v  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o = 32'h0;
        unique case (funct3_i)
            3'b000:  rdata_o = {{24{byte_v[7]}}, byte_v};
            3'b100:  rdata_o = {24'h0, byte_v};
            3'b001:  rdata_o = {{16{half_v[15]}}, half_v};
            3'b101:  rdata_o = {16'h0, half_v};
            3'b010:  rdata_o = rdata_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: access check, req/ack bus handshake, timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_lsu_clk,
    input  logic        i_lsu_rst_n,
    input  logic        i_lsu_Valid,
    input  logic        i_lsu_MemWrite,
    input  logic [2:0]  i_lsu_Funct3,
    input  logic [31:0] i_lsu_Addr,
    input  logic [31:0] i_lsu_WriteData,
    output logic        o_lsu_Busy,
    output logic        o_lsu_Done,
    output logic [31:0] o_lsu_ReadData,
    output logic [1:0]  o_lsu_Fault,
    output logic        o_lsu_BusReq,
    output logic        o_lsu_BusWe,
    output logic [31:0] o_lsu_BusAddr,
    output logic [31:0] o_lsu_BusWData,
    output logic [3:0]  o_lsu_BusBe,
    input  logic        i_lsu_BusAck,
    input  logic [31:0] i_lsu_BusRData
);

    localparam int unsigned      CntW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT_CYCLES);

    lsu_state_t      state_q, state_d;
    lsu_fault_t      fault_q, fault_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            accept;

    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (i_lsu_BusRData),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    // State register
    always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
        if (!i_lsu_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access registers, timeout counter and result registers
    always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
        if (!i_lsu_rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            fault_q <= FAULT_NONE;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= i_lsu_MemWrite;
                f3_q    <= i_lsu_Funct3;
                addr_q  <= i_lsu_Addr;
                wdata_q <= i_lsu_WriteData;
            end
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: access check, ack/timeout handling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_lsu_Valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    rdata_d = 32'h0;
                    if (f3_illegal(i_lsu_MemWrite, i_lsu_Funct3)) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = DONE;
                    end else if (addr_misaligned(i_lsu_Funct3, i_lsu_Addr[1:0])) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = DONE;
                    end else begin
                        fault_d = FAULT_NONE;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ack takes priority over a timeout expiring in the same cycle
                if (i_lsu_BusAck) begin
                    rdata_d = we_q ? 32'h0 : al_rdata;
                    fault_d = FAULT_NONE;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == CntMax) begin
                        rdata_d = 32'h0;
                        fault_d = FAULT_TIMEOUT;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: bus signals only while requesting, so faulted accesses never touch the bus
    always_comb begin
        o_lsu_Busy     = (state_q != IDLE);
        o_lsu_Done     = (state_q == DONE);
        o_lsu_BusReq   = (state_q == REQ);
        o_lsu_BusWe    = o_lsu_BusReq && we_q;
        o_lsu_BusAddr  = o_lsu_BusReq ? {addr_q[31:2], 2'b00} : 32'h0;
        o_lsu_BusBe    = o_lsu_BusWe ? al_be : 4'b0000;
        o_lsu_BusWData = o_lsu_BusWe ? al_wdata : 32'h0;
        o_lsu_ReadData = rdata_q;
        o_lsu_Fault    = fault_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (TIMEOUT_CYCLES = 4).
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic [31:0] read_data;
    logic [1:0]  fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  fault;
        logic [31:0] rd;
        int          req;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cnt = 0;
    bit prev_req = 0;

    load_store_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_lsu_clk       (clk),
        .i_lsu_rst_n     (rst_n),
        .i_lsu_Valid     (valid),
        .i_lsu_MemWrite  (mem_write),
        .i_lsu_Funct3    (funct3),
        .i_lsu_Addr      (addr_in),
        .i_lsu_WriteData (wdata_in),
        .o_lsu_Busy      (busy),
        .o_lsu_Done      (done),
        .o_lsu_ReadData  (read_data),
        .o_lsu_Fault     (fault),
        .o_lsu_BusReq    (bus_req),
        .o_lsu_BusWe     (bus_we),
        .o_lsu_BusAddr   (bus_addr),
        .o_lsu_BusWData  (bus_wdata),
        .o_lsu_BusBe     (bus_be),
        .i_lsu_BusAck    (bus_ack),
        .i_lsu_BusRData  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitor: compares bus requests and completions against the queues
    initial begin
        bus_exp_t  b;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cnt  = 0;
                prev_req = 0;
            end else begin
                if (bus_req) begin
                    req_cnt++;
                    if (!prev_req) begin
                        if (bus_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_busreq: got addr %h want none", bus_addr);
                        end else begin
                            b = bus_q.pop_front();
                            check("bus_addr", bus_addr, b.addr);
                            check("bus_we", {31'h0, bus_we}, {31'h0, b.we});
                            check("bus_be", {28'h0, bus_be}, {28'h0, b.be});
                            check("bus_wdata", bus_wdata, b.wd);
                        end
                    end
                end
                prev_req = bus_req;
                if (done) begin
                    if (resp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                    end else begin
                        r = resp_q.pop_front();
                        check("done_cycle", cyc, r.cyc);
                        check("fault", {30'h0, fault}, {30'h0, r.fault});
                        check("read_data", read_data, r.rd);
                        check("req_cycles", req_cnt, r.req);
                    end
                    req_cnt = 0;
                end
            end
        end
    end

    // Issue one access; k>=0 acks in REQ cycle k+1 (cycle 1+k), k<0 never acks
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int k, input logic [31:0] rd,
                         input bit exp_bus, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [1:0] exp_fault,
                         input logic [31:0] exp_rd, input int exp_lat, input int exp_req,
                         input bit track);
        int        c0;
        bit        seen;
        bus_exp_t  b;
        resp_exp_t r;
        @(negedge clk);
        c0 = cyc;
        if (exp_bus) begin
            b.addr = addr & 32'hFFFF_FFFC;
            b.we   = we;
            b.be   = exp_be;
            b.wd   = exp_wd;
            bus_q.push_back(b);
        end
        if (track) begin
            r.cyc   = c0 + exp_lat;
            r.fault = exp_fault;
            r.rd    = exp_rd;
            r.req   = exp_req;
            resp_q.push_back(r);
        end
        valid     = 1'b1;
        mem_write = we;
        funct3    = f3;
        addr_in   = addr;
        wdata_in  = wd;
        @(posedge clk);
        #1 valid = 1'b0;
        if (k >= 0) begin
            repeat (k + 1) @(negedge clk);
            bus_ack   = 1'b1;
            bus_rdata = rd;
            @(posedge clk);
            #1 bus_ack = 1'b0;
        end
        if (track) begin
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL done_wait: got no done within 40 cycles want done");
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr_in   = 32'h0;
        wdata_in  = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;

        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_fault", {30'h0, fault}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        #10 rst_n = 1'b1;

        //     we    f3      addr          wd            k   rdata         bus be       exp_wd        flt    exp_rd        lat req trk
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 32'hFFFF_FFFF, 1, 4'b1000, 32'hA5A5_A5A5, 2'b00, 32'h0000_0000, 4, 3, 1);
        issue(1'b0, 3'b000, 32'h0000_2001, 32'h0,         0, 32'h0000_8000, 1, 4'b0000, 32'h0,         2'b00, 32'hFFFF_FF80, 2, 1, 1);
        issue(1'b0, 3'b100, 32'h0000_2001, 32'h0,         0, 32'h0000_8000, 1, 4'b0000, 32'h0,         2'b00, 32'h0000_0080, 2, 1, 1);
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0,         1, 32'h8001_1234, 1, 4'b0000, 32'h0,         2'b00, 32'hFFFF_8001, 3, 2, 1);
        issue(1'b0, 3'b101, 32'h0000_2002, 32'h0,         0, 32'h8001_1234, 1, 4'b0000, 32'h0,         2'b00, 32'h0000_8001, 2, 1, 1);
        issue(1'b0, 3'b101, 32'h0000_2000, 32'h0,         0, 32'h8001_1234, 1, 4'b0000, 32'h0,         2'b00, 32'h0000_1234, 2, 1, 1);
        issue(1'b0, 3'b000, 32'h0000_2003, 32'h0,         0, 32'h7F00_0000, 1, 4'b0000, 32'h0,         2'b00, 32'h0000_007F, 2, 1, 1);
        issue(1'b0, 3'b010, 32'h0000_2006, 32'h0,        -1, 32'h0,         0, 4'b0000, 32'h0,         2'b01, 32'h0000_0000, 1, 0, 1);
        issue(1'b0, 3'b001, 32'h0000_2001, 32'h0,        -1, 32'h0,         0, 4'b0000, 32'h0,         2'b01, 32'h0000_0000, 1, 0, 1);
        issue(1'b0, 3'b011, 32'h0000_3000, 32'h0,        -1, 32'h0,         0, 4'b0000, 32'h0,         2'b11, 32'h0000_0000, 1, 0, 1);
        issue(1'b0, 3'b110, 32'h0000_3000, 32'h0,        -1, 32'h0,         0, 4'b0000, 32'h0,         2'b11, 32'h0000_0000, 1, 0, 1);
        issue(1'b1, 3'b100, 32'h0000_3000, 32'h1111_2222,-1, 32'h0,         0, 4'b0000, 32'h0,         2'b11, 32'h0000_0000, 1, 0, 1);
        issue(1'b1, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 0, 32'h5555_5555, 1, 4'b1100, 32'hABCD_ABCD, 2'b00, 32'h0000_0000, 2, 1, 1);
        issue(1'b1, 3'b001, 32'h0000_5001, 32'h1234_ABCD,-1, 32'h0,         0, 4'b0000, 32'h0,         2'b01, 32'h0000_0000, 1, 0, 1);
        issue(1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 1, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 2'b00, 32'h0000_0000, 3, 2, 1);
        // Timeout: four REQ cycles, then done with fault 10
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0,        -1, 32'h0,         1, 4'b0000, 32'h0,         2'b10, 32'h0000_0000, 5, 4, 1);
        // Ack in the fourth REQ cycle beats the timeout
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0,         3, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0,         2'b00, 32'hDEAD_BEEF, 5, 4, 1);
        issue(1'b0, 3'b010, 32'h0000_4004, 32'h0,         0, 32'h1234_5678, 1, 4'b0000, 32'h0,         2'b00, 32'h1234_5678, 2, 1, 1);

        // Reset in the middle of REQ: access abandoned, no done
        issue(1'b0, 3'b010, 32'h0000_7000, 32'h0,        -1, 32'h0,         1, 4'b0000, 32'h0,         2'b00, 32'h0,         0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bus_req", {31'h0, bus_req}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        #3 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("postrst_busy", {31'h0, busy}, 32'h0);
            check("postrst_done", {31'h0, done}, 32'h0);
        end
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stray_ack_busy", {31'h0, busy}, 32'h0);
            check("stray_ack_done", {31'h0, done}, 32'h0);
        end
        issue(1'b0, 3'b010, 32'h0000_7000, 32'h0,         0, 32'h1357_9BDF, 1, 4'b0000, 32'h0,         2'b00, 32'h1357_9BDF, 2, 1, 1);

        repeat (5) @(negedge clk);
        check("resp_queue_empty", resp_q.size(), 32'h0);
        check("bus_queue_empty", bus_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
